spi_fl_burst_reader: RTL
========================

Name: spi_fl_burst_reader

Overview:
- Upstream sequencer for the SPI flash master controller.
- Takes one burst-read request (start address, word count, command framing) and splits it into consecutive 32-bit read transactions on the master's valid/tready interface, advancing the address by 4 bytes each time.
- Returned words go into an internal FIFO that the CPU/DMA side drains with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, read-data FIFO depth in 32-bit words; power of two, 2..64.
- MAX_WORDS_W, 8, width of the burst word-count field.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  burst request valid
- req_ready_o  out  1  sequencer idle, request accepted when req_valid_i & req_ready_o
- req_addr_i  in  32  flash byte start address
- req_nwords_i  in  MAX_WORDS_W  words to read; 0 = no-op
- req_command_i  in  8  flash read opcode
- req_commtype_i  in  3  command type forwarded to master
- req_frame_struct_i  in  10  frame structure forwarded
- req_dummy_i  in  4  dummy cycles forwarded
- req_dtr_i  in  1  DTR enable forwarded
- req_4byte_i  in  1  4-byte addressing forwarded
- req_spimode_i  in  2  spi mode forwarded
- abort_i  in  1  stop burst after in-flight word
- m_address_o  out  32  to master address_i
- m_command_o  out  8  to master command_i
- m_commtype_o  out  3  to master commtype_i
- m_frame_struct_o  out  10  to master frame_struct_i
- m_dummy_o  out  4  to master dummy_cycles_i
- m_dtr_o  out  1  to master dtr_en_i
- m_4byte_o  out  1  to master fourbyteaddr_on_i
- m_spimode_o  out  2  to master spimode_i
- m_ndata_bits_o  out  7  constant 7'd32
- m_valid_o  out  1  to master validflag_i
- m_tready_i  in  1  from master tready_o
- m_rdata_i  in  32  from master data_out_o
- rd_valid_o  out  1  FIFO head valid
- rd_ready_i  in  1  consumer pop
- rd_data_o  out  32  FIFO head word
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse at burst end
- aborted_o  out  1  sticky; set if last burst ended by abort; cleared on next accept

Behaviour:
- Reset values:
  - req_ready_o=1; every other output 0.
  - m_ndata_bits_o=32.
  - FIFO empty; state IDLE.
- FSM states:
  - IDLE: req_ready_o=1.
    - On accept: latch all req fields. Remaining count rem=req_nwords_i, aborted_o cleared.
    - If rem==0: pulse done_o next cycle, stay IDLE.
    - Else go ISSUE.
  - ISSUE: wait for m_tready_i=1 and the credit check free+0 >= 1, where free = FIFO_DEPTH - count.
    - Then assert m_valid_o for exactly one cycle with the current address and go WAIT_BUSY.
  - WAIT_BUSY: wait m_tready_i=0 (master drops tready the cycle after accept), then go WAIT_DONE.
  - WAIT_DONE: on first cycle m_tready_i=1, push m_rdata_i into the FIFO, rem-=1, address+=4, then:
    - rem==0: go FINISH.
    - abort latched: set aborted_o, go FINISH.
    - otherwise: go ISSUE.
  - FINISH: done_o=1 for one cycle, go IDLE.
- Credit: only one word is ever in flight; ISSUE blocks while the FIFO is full, so a push never overflows.
- Address wrap:
  - When m_4byte_o=0, address increments mod 2^24 and bits [31:24] are held 0.
  - Otherwise it increments mod 2^32.
- Abort:
  - abort_i sampled in any non-IDLE state and latched.
  - In ISSUE with no word in flight: go FINISH immediately, set aborted_o.
  - An in-flight word always completes and is pushed.
  - abort_i in IDLE is ignored.
- FIFO:
  - First-word fall-through. rd_valid_o = !empty; pop on rd_valid_o & rd_ready_i.
  - Simultaneous push and pop when full or empty is legal; count stays consistent.
  - The FIFO is not flushed at burst end; leftover words stay readable.
- busy_o=1 in all states except IDLE.
- m_* fields are stable from ISSUE through WAIT_DONE.
- Reset mid-burst: all state is cleared asynchronously and FIFO contents are discarded. The master resets on the same rst_i.

Decomposition:
- Package spi_fl_pkg holds:
  - FSM state encodings (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH; 3 bits).
  - SPI_DATA_W=32, ADDR_STEP=4, ADDR24_MASK.
- Sub-module spi_fl_rdfifo: a synchronous FWFT FIFO with parameters DEPTH and W. Ports: push, din, pop, dout, empty, full, count.

Test Plan:
1. Request addr=0x000100, nwords=3, master model returns 0xA0,0xA1,0xA2 -> three m_valid_o pulses with addresses 0x100, 0x104, 0x108; FIFO pops A0,A1,A2 in order; done_o pulses once; busy_o returns to 0.
2. Request addr=0xFFFFFC, nwords=2, 4byte=0 -> issued addresses 0xFFFFFC then 0x000000. Same with 4byte=1 -> 0xFFFFFC, 0x1000000.
3. FIFO_DEPTH=8, nwords=12, rd_ready_i=0 -> exactly 8 transactions issued, sequencer stalls in ISSUE. Pop 1 word -> one more is issued. Draining all completes 12.
4. abort_i pulsed during the 2nd word of a 10-word burst -> 2 words in FIFO, done_o pulses, aborted_o=1. The next accepted request clears aborted_o.
5. nwords=0 -> no m_valid_o; done_o pulses one cycle after accept; req_ready_o stays 1.
6. rst_i asserted in WAIT_DONE with 3 words buffered -> outputs immediately at reset values; rd_valid_o=0; the next request runs normally.

Source files
------------

// File: rtl/spi_fl_pkg.sv
// Shared types and constants for the SPI flash burst-read sequencer.
package spi_fl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_e;

    localparam int unsigned SPI_DATA_W  = 32;
    localparam logic [31:0] ADDR_STEP   = 32'd4;
    localparam logic [31:0] ADDR24_MASK = 32'h00FF_FFFF;

    // Next word address; 3-byte addressing wraps inside the low 16 MiB.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fourbyte);
        logic [31:0] sum;
        sum = addr + ADDR_STEP;
        return fourbyte ? sum : (sum & ADDR24_MASK);
    endfunction

endpackage

// File: rtl/spi_fl_rdfifo.sv
// First-word fall-through FIFO for returned read words.
module spi_fl_rdfifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    // A pop on empty is ignored; a push on full is only taken with a pop.
    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/spi_fl_burst_reader.sv
// Splits a burst-read request into single-word SPI master transactions
// and buffers the returned words for the CPU/DMA consumer.
module spi_fl_burst_reader
    import spi_fl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAX_WORDS_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic [MAX_WORDS_W-1:0] req_nwords_i,
    input  logic [7:0]             req_command_i,
    input  logic [2:0]             req_commtype_i,
    input  logic [9:0]             req_frame_struct_i,
    input  logic [3:0]             req_dummy_i,
    input  logic                   req_dtr_i,
    input  logic                   req_4byte_i,
    input  logic [1:0]             req_spimode_i,
    input  logic                   abort_i,
    output logic [31:0]            m_address_o,
    output logic [7:0]             m_command_o,
    output logic [2:0]             m_commtype_o,
    output logic [9:0]             m_frame_struct_o,
    output logic [3:0]             m_dummy_o,
    output logic                   m_dtr_o,
    output logic                   m_4byte_o,
    output logic [1:0]             m_spimode_o,
    output logic [6:0]             m_ndata_bits_o,
    output logic                   m_valid_o,
    input  logic                   m_tready_i,
    input  logic [31:0]            m_rdata_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [31:0]            rd_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_e                 state_q;
    logic [31:0]            addr_q, addr_d;
    logic [7:0]             cmd_q;
    logic [2:0]             commtype_q;
    logic [9:0]             frame_q;
    logic [3:0]             dummy_q;
    logic                   dtr_q, fourbyte_q;
    logic [1:0]             spimode_q;
    logic [MAX_WORDS_W-1:0] rem_q;
    logic                   abort_q, m_valid_q, done_q, aborted_q;

    logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0]       fifo_count;
    logic                   credit_ok, abort_now;

    // Credit, abort view and next address for the sequencer.
    always_comb begin
        credit_ok = (DEPTH_C - fifo_count) != '0;
        abort_now = abort_q | abort_i;
        addr_d    = next_addr(addr_q, fourbyte_q);
        fifo_push = (state_q == WAIT_DONE) & m_tready_i & ~fifo_full;
        fifo_pop  = rd_ready_i & ~fifo_empty;
    end

    // Burst sequencer with registered handshake and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cmd_q      <= '0;
            commtype_q <= '0;
            frame_q    <= '0;
            dummy_q    <= '0;
            dtr_q      <= 1'b0;
            fourbyte_q <= 1'b0;
            spimode_q  <= '0;
            rem_q      <= '0;
            abort_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            if (state_q != IDLE && abort_i) abort_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q     <= req_4byte_i ? req_addr_i : (req_addr_i & ADDR24_MASK);
                        cmd_q      <= req_command_i;
                        commtype_q <= req_commtype_i;
                        frame_q    <= req_frame_struct_i;
                        dummy_q    <= req_dummy_i;
                        dtr_q      <= req_dtr_i;
                        fourbyte_q <= req_4byte_i;
                        spimode_q  <= req_spimode_i;
                        rem_q      <= req_nwords_i;
                        aborted_q  <= 1'b0;
                        abort_q    <= 1'b0;
                        if (req_nwords_i == '0) done_q  <= 1'b1;
                        else                    state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort_now) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= FINISH;
                    end else if (m_tready_i && credit_ok) begin
                        m_valid_q <= 1'b1;
                        state_q   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!m_tready_i) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (m_tready_i) begin
                        rem_q  <= rem_q - MAX_WORDS_W'(1);
                        addr_q <= addr_d;
                        if (rem_q == MAX_WORDS_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else if (abort_now) begin
                            aborted_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= FINISH;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_fl_rdfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SPI_DATA_W)
    ) u_rdfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .din_i   (m_rdata_i),
        .pop_i   (fifo_pop),
        .dout_o  (rd_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign req_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign m_valid_o        = m_valid_q;
    assign m_address_o      = addr_q;
    assign m_command_o      = cmd_q;
    assign m_commtype_o     = commtype_q;
    assign m_frame_struct_o = frame_q;
    assign m_dummy_o        = dummy_q;
    assign m_dtr_o          = dtr_q;
    assign m_4byte_o        = fourbyte_q;
    assign m_spimode_o      = spimode_q;
    assign m_ndata_bits_o   = 7'd32;
    assign rd_valid_o       = ~fifo_empty;

endmodule
